// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the dice game controller.
//               It holds the FSM state encodings, the choose-block verdict
//               codes and the die and score geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Score geometry and game constants
    localparam int SCORE_W = 4;
    localparam int DIE_W   = 3;
    localparam int DIE_MAX = 6;
    localparam int TARGET  = 15;

    typedef logic [2:0]         state_t;
    typedef logic [1:0]         result_t;
    typedef logic [SCORE_W-1:0] score_t;

    // FSM state encodings, exported on state_o for the debug LEDs
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;
    localparam logic [2:0] ST_LOST  = 3'd5;

    // Verdict codes from the choose block. Code 2'b11 is illegal.
    localparam logic [1:0] RES_CONTINUE = 2'b00;
    localparam logic [1:0] RES_LOST     = 2'b01;
    localparam logic [1:0] RES_WON      = 2'b10;

    // Next value of the free-running die: 1..DIE_MAX, then back to 1.
    function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] cur);
        if (cur >= DIE_W'(DIE_MAX)) begin
            return DIE_W'(1);
        end
        return cur + DIE_W'(1);
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_rise
// Description : Rising-edge detector for a level that is already
//               synchronised. It uses one history flop and an AND gate.
//               A level held high gives exactly one single-cycle rise_o.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset (history cleared)
//               in_i    - synchronised level input
//               rise_o  - high for the one cycle where in_i=1 and history=0
// Revision    : 1.0 - initial release
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign rise_o = in_i & ~in_q;

endmodule : edge_rise
`default_nettype wire

// File: rtl/dice_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dice_game_ctrl
// Description : Top-level sequencer for the dice game. A roll-button edge
//               samples a free-running 1..6 die. The roll and the current
//               score go to the external choose/check block, and the
//               controller then commits that block's verdict. It owns the
//               score, the turn count and the won/lost flags.
// Ports       : clk, rst_n             - clock, async active-low reset
//               start_i, roll_i        - synchronised button levels
//               die_o                  - last roll (0 before first roll)
//               score_o, turn_o        - committed score, completed rolls
//               state_o                - FSM encoding for debug LEDs
//               won_o, lost_o          - game outcome flags
//               chs_pulse_o            - one-cycle request to choose block
//               chs_num_o, chs_score_o - roll / score under evaluation
//               chs_pulse_i            - verdict strobe from choose block
//               chs_result_i           - verdict code
//               chs_new_score_i        - proposed new score
// Revision    : 1.0 - initial release
// ============================================================================
module dice_game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_TURNS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               roll_i,
    output logic [DIE_W-1:0]   die_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         turn_o,
    output logic [2:0]         state_o,
    output logic               won_o,
    output logic               lost_o,
    output logic               chs_pulse_o,
    output logic [DIE_W-1:0]   chs_num_o,
    output logic [SCORE_W-1:0] chs_score_o,
    input  logic               chs_pulse_i,
    input  logic [1:0]         chs_result_i,
    input  logic [SCORE_W-1:0] chs_new_score_i
);

    // MAX_TURNS is limited to 1..15, so it fits the 4-bit turn counter.
    localparam logic [3:0] C_MAX_TURNS = 4'(MAX_TURNS);

    logic               start_rise;
    logic               roll_rise;

    state_t             state_q, state_d;
    logic [DIE_W-1:0]   cnt_q;
    logic [DIE_W-1:0]   die_q, die_d;
    score_t             score_q, score_d;
    logic [3:0]         turn_q, turn_d;
    logic [3:0]         turn_inc;

    // ------------------------------------------------------------------
    // Button edge detectors
    // ------------------------------------------------------------------
    edge_rise u_start_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (start_i),
        .rise_o (start_rise)
    );

    edge_rise u_roll_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (roll_i),
        .rise_o (roll_rise)
    );

    // ------------------------------------------------------------------
    // Free-running die. It advances in every state, so the value sampled
    // depends on when the user presses roll.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= DIE_W'(1);
        end else begin
            cnt_q <= die_next(cnt_q);
        end
    end

    assign turn_inc = turn_q + 4'd1;

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        die_d   = die_q;
        score_d = score_q;
        turn_d  = turn_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_READY;
                    score_d = '0;
                    turn_d  = '0;
                end
            end

            ST_READY: begin
                if (roll_rise) begin
                    die_d   = cnt_q;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            // die_q and score_q stay frozen here, because the choose block
            // samples them combinationally at some later time.
            ST_WAIT: begin
                if (chs_pulse_i) begin
                    turn_d = turn_inc;
                    case (chs_result_i)
                        RES_CONTINUE: begin
                            score_d = chs_new_score_i;
                            state_d = (turn_inc == C_MAX_TURNS) ? ST_LOST : ST_READY;
                        end
                        RES_LOST: begin
                            score_d = '0;
                            state_d = ST_LOST;
                        end
                        RES_WON: begin
                            score_d = chs_new_score_i;
                            state_d = ST_WON;
                        end
                        default: begin
                            // An illegal verdict ends the game and keeps the score.
                            state_d = ST_LOST;
                        end
                    endcase
                end
            end

            ST_WON, ST_LOST: begin
                if (start_rise) begin
                    state_d = ST_READY;
                    score_d = '0;
                    turn_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            die_q   <= '0;
            score_q <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            die_q   <= die_d;
            score_q <= score_d;
            turn_q  <= turn_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign die_o       = die_q;
    assign score_o     = score_q;
    assign turn_o      = turn_q;
    assign state_o     = state_q;
    assign won_o       = (state_q == ST_WON);
    assign lost_o      = (state_q == ST_LOST);
    assign chs_pulse_o = (state_q == ST_ISSUE);
    assign chs_num_o   = die_q;
    assign chs_score_o = score_q;

endmodule : dice_game_ctrl
`default_nettype wire

// File: tb/tb_dice_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_game_ctrl
// Description : Directed self-checking bench for dice_game_ctrl. It uses
//               MAX_TURNS=3 so the forced loss on the last turn is reached
//               quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_game_ctrl;

    localparam int C_MAX_TURNS = 3;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       roll_i;
    logic [2:0] die_o;
    logic [3:0] score_o;
    logic [3:0] turn_o;
    logic [2:0] state_o;
    logic       won_o;
    logic       lost_o;
    logic       chs_pulse_o;
    logic [2:0] chs_num_o;
    logic [3:0] chs_score_o;
    logic       chs_pulse_i;
    logic [1:0] chs_result_i;
    logic [3:0] chs_new_score_i;

    int total;
    int bad;

    // Expected die counter: 1..6 from reset, advancing on every edge.
    int m_cnt;

    dice_game_ctrl #(
        .MAX_TURNS (C_MAX_TURNS)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .roll_i          (roll_i),
        .die_o           (die_o),
        .score_o         (score_o),
        .turn_o          (turn_o),
        .state_o         (state_o),
        .won_o           (won_o),
        .lost_o          (lost_o),
        .chs_pulse_o     (chs_pulse_o),
        .chs_num_o       (chs_num_o),
        .chs_score_o     (chs_score_o),
        .chs_pulse_i     (chs_pulse_i),
        .chs_result_i    (chs_result_i),
        .chs_new_score_i (chs_new_score_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 1;
        else        m_cnt <= (m_cnt == 6) ? 1 : m_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic press_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
    endtask

    // Raise roll in a cycle where the die shows v. On return, the DUT is in
    // ISSUE and the request pulse should be high.
    task automatic roll_at(input int v, input string tag);
        int n;
        n = 0;
        while (m_cnt != v && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cnt_found"}, m_cnt, v);
        roll_i = 1'b1;
        @(negedge clk);
        roll_i = 1'b0;
        chk({tag, "_die"}, die_o, v);
        chk({tag, "_pulse"}, chs_pulse_o, 1);
        @(negedge clk);
        chk({tag, "_pulse_off"}, chs_pulse_o, 0);
        chk({tag, "_wait"}, state_o, 3);
    endtask

    task automatic verdict(input logic [1:0] res, input logic [3:0] ns);
        chs_pulse_i     = 1'b1;
        chs_result_i    = res;
        chs_new_score_i = ns;
        @(negedge clk);
        chs_pulse_i     = 1'b0;
    endtask

    initial begin
        int pulses;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        roll_i = 1'b0;
        chs_pulse_i = 1'b0;
        chs_result_i = 2'b00;
        chs_new_score_i = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_die", die_o, 0);
        chk("rst_score", score_o, 0);
        chk("rst_turn", turn_o, 0);
        chk("rst_won", won_o, 0);
        chk("rst_lost", lost_o, 0);
        chk("rst_pulse", chs_pulse_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start, then roll a 4, then continue with score 4
        press_start();
        chk("start_ready", state_o, 1);
        roll_at(4, "r1");
        chk("r1_num", chs_num_o, 4);
        verdict(2'b00, 4'd4);
        chk("v1_score", score_o, 4);
        chk("v1_turn", turn_o, 1);
        chk("v1_state", state_o, 1);
        chk("v1_chs_score", chs_score_o, 4);

        // Score 9, then win with 15
        roll_at(2, "r2");
        verdict(2'b00, 4'd9);
        chk("v2_score", score_o, 9);
        roll_at(6, "r3");
        verdict(2'b10, 4'd15);
        chk("won_flag", won_o, 1);
        chk("won_state", state_o, 4);
        chk("won_score", score_o, 15);
        chk("won_turn", turn_o, 3);
        roll_i = 1'b1;
        @(negedge clk);
        roll_i = 1'b0;
        @(negedge clk);
        chk("won_roll_state", state_o, 4);
        chk("won_roll_die", die_o, 6);
        chk("won_roll_pulse", chs_pulse_o, 0);
        press_start();
        chk("restart_state", state_o, 1);
        chk("restart_score", score_o, 0);
        chk("restart_turn", turn_o, 0);
        chk("restart_won", won_o, 0);
        chk("restart_die", die_o, 6);

        // Three continues: forced loss on the last turn
        roll_at(1, "r4");
        verdict(2'b00, 4'd1);
        roll_at(3, "r5");
        verdict(2'b00, 4'd2);
        chk("max2_state", state_o, 1);
        roll_at(5, "r6");
        verdict(2'b00, 4'd3);
        chk("max_lost", lost_o, 1);
        chk("max_state", state_o, 5);
        chk("max_turn", turn_o, 3);
        chk("max_score", score_o, 3);

        // Lost verdict forces score to 0
        press_start();
        roll_at(2, "r7");
        verdict(2'b01, 4'd7);
        chk("l01_lost", lost_o, 1);
        chk("l01_score", score_o, 0);
        chk("l01_turn", turn_o, 1);

        // Stray verdict in READY, a held roll, ignored inputs in WAIT, illegal verdict
        press_start();
        roll_at(3, "r8");
        verdict(2'b00, 4'd5);
        verdict(2'b10, 4'd12);
        chk("stray_ready_state", state_o, 1);
        chk("stray_ready_turn", turn_o, 1);
        chk("stray_ready_score", score_o, 5);
        roll_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (chs_pulse_o) pulses++;
        end
        roll_i = 1'b0;
        chk("held_pulses", pulses, 1);
        chk("held_state", state_o, 3);
        begin
            int d_held;
            d_held = die_o;
            roll_i = 1'b1;
            start_i = 1'b1;
            @(negedge clk);
            roll_i = 1'b0;
            start_i = 1'b0;
            @(negedge clk);
            chk("wait_ign_state", state_o, 3);
            chk("wait_ign_die", die_o, d_held);
            chk("wait_ign_pulse", chs_pulse_o, 0);
        end
        verdict(2'b11, 4'd9);
        chk("ill_state", state_o, 5);
        chk("ill_score", score_o, 5);
        chk("ill_turn", turn_o, 2);

        // Asynchronous reset while in WAIT, then a stray verdict
        press_start();
        roll_at(4, "r9");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_die", die_o, 0);
        chk("arst_score", score_o, 0);
        chk("arst_turn", turn_o, 0);
        chk("arst_pulse", chs_pulse_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        verdict(2'b10, 4'd15);
        chk("arst_stray_state", state_o, 0);
        chk("arst_stray_won", won_o, 0);
        chk("arst_stray_score", score_o, 0);
        chk("arst_stray_turn", turn_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dice_game_ctrl
`default_nettype wire
